// File: rtl/gpio_out_ctrl.sv
// Memory-mapped GPIO output register with atomic set/clear/toggle writes.
// Define GPIO_OUT_PULSE_EN to build the timed pin-inversion pulse engine.
module gpio_out_ctrl #(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] RESET_VAL = 32'h0,
    parameter int          LEN_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       addr,
    input  logic [31:0]      wdata,
    input  logic             we,
    input  logic             re,
    output logic [31:0]      rdata,
    output logic             ready,
    output logic [WIDTH-1:0] GPIO_o,
    output logic             busy
);

    localparam logic [WIDTH-1:0] RST_PINS = RESET_VAL[WIDTH-1:0];

    localparam logic [2:0] A_DATA  = 3'd0;
    localparam logic [2:0] A_SET   = 3'd1;
    localparam logic [2:0] A_CLR   = 3'd2;
    localparam logic [2:0] A_TOG   = 3'd3;
    localparam logic [2:0] A_PULSE = 3'd4;
    localparam logic [2:0] A_LEN   = 3'd5;
    localparam logic [2:0] A_STAT  = 3'd6;

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_nxt;
    logic [WIDTH-1:0] pin_nxt;
    logic [WIDTH-1:0] wbits;
    logic [31:0]      rd_val;
    logic             unused_bits;

    assign wbits       = wdata[WIDTH-1:0];
    assign unused_bits = ^{wdata, LEN_W[0]};

    always_comb begin
        data_nxt = data_q;
        if (we) begin
            unique case (addr)
                A_DATA:  data_nxt = wbits;
                A_SET:   data_nxt = data_q | wbits;
                A_CLR:   data_nxt = data_q & ~wbits;
                A_TOG:   data_nxt = data_q ^ wbits;
                default: data_nxt = data_q;
            endcase
        end
    end

`ifdef GPIO_OUT_PULSE_EN

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic             wr_pulse;
    logic             wr_len;
    logic             idle;
    logic             pulse_start;
    logic             pulse_end;
    logic             busy_nxt;

    assign wr_pulse    = we && (addr == A_PULSE);
    assign wr_len      = we && (addr == A_LEN);
    assign idle        = (state == IDLE);
    assign pulse_start = wr_pulse && idle && (len_q != '0);
    assign pulse_end   = !idle && (cnt_q == LEN_W'(1));

    // MASK is frozen while a pulse runs so it always restores what it inverted
    assign mask_nxt = (wr_pulse && idle) ? wbits : mask_q;
    assign busy_nxt = pulse_start || (!idle && !pulse_end);
    assign busy     = (state == ACTIVE);
    assign pin_nxt  = data_nxt ^ (busy_nxt ? mask_nxt : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mask_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else begin
            mask_q <= mask_nxt;
            if (wr_len) begin
                len_q <= wdata[LEN_W-1:0];
            end
            unique case (state)
                IDLE: begin
                    if (pulse_start) begin
                        cnt_q <= len_q;
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    cnt_q <= cnt_q - LEN_W'(1);
                    if (pulse_end) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`else

    assign busy    = 1'b0;
    assign pin_nxt = data_nxt;

`endif

    always_comb begin
        rd_val = '0;
        unique case (addr)
            A_DATA:  rd_val = 32'(data_q);
`ifdef GPIO_OUT_PULSE_EN
            A_PULSE: rd_val = 32'(mask_q);
            A_LEN:   rd_val = 32'(len_q);
            A_STAT:  rd_val = {16'(cnt_q), 15'd0, busy};
`endif
            default: rd_val = '0;
        endcase
    end

    // A combined we+re is a write, so it returns zero data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RST_PINS;
            GPIO_o <= RST_PINS;
            ready  <= 1'b0;
            rdata  <= '0;
        end else begin
            data_q <= data_nxt;
            GPIO_o <= pin_nxt;
            ready  <= we || re;
            rdata  <= (re && !we) ? rd_val : '0;
        end
    end

endmodule

// File: tb/tb_gpio_out_ctrl.sv
// Bench for gpio_out_ctrl: vector table, corner sequences, random traffic
// checked against a cycle-count based model of the register map.
module tb_gpio_out_ctrl;

    localparam int W = 8;
`ifdef GPIO_OUT_PULSE_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    addr = '0;
    logic [31:0]   wdata = '0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [31:0]   rdata;
    logic          ready;
    logic [W-1:0]  gpio;
    logic          busy;

    gpio_out_ctrl #(
        .WIDTH(W),
        .RESET_VAL(32'h0),
        .LEN_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .wdata(wdata),
        .we(we),
        .re(re),
        .rdata(rdata),
        .ready(ready),
        .GPIO_o(gpio),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // model: a pulse is an interval of cycle numbers [start, m_end)
    logic [W-1:0]  m_data;
    logic [W-1:0]  m_mask;
    logic [15:0]   m_len;
    int            cyc = 0;
    int            m_end = 0;
    logic          e_ready;
    logic [31:0]   e_rdata;

    typedef struct {
        bit          w;
        bit          r;
        logic [2:0]  a;
        logic [31:0] d;
        logic [W-1:0] g;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        return PEN && (cyc < m_end);
    endfunction

    function automatic logic [31:0] reg_val(input logic [2:0] a);
        logic [31:0] v;
        int cnt;
        cnt = m_busy() ? (m_end - cyc) : 0;
        v = '0;
        case (a)
            3'd0: v = 32'(m_data);
            3'd4: v = PEN ? 32'(m_mask) : 32'h0;
            3'd5: v = PEN ? 32'(m_len) : 32'h0;
            3'd6: v = PEN ? {16'(cnt), 15'd0, m_busy()} : 32'h0;
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_data = '0;
        m_mask = '0;
        m_len = '0;
        m_end = 0;
    endtask

    task automatic model_edge(input bit w, input bit r, input logic [2:0] a,
                              input logic [31:0] d);
        bit pre_busy;
        pre_busy = m_busy();
        e_ready = w | r;
        e_rdata = w ? 32'h0 : (r ? reg_val(a) : 32'h0);
        if (w) begin
            case (a)
                3'd0: m_data = d[W-1:0];
                3'd1: m_data = m_data | d[W-1:0];
                3'd2: m_data = m_data & ~d[W-1:0];
                3'd3: m_data = m_data ^ d[W-1:0];
                3'd4: if (PEN && !pre_busy) begin
                    m_mask = d[W-1:0];
                    if (m_len != 0) m_end = cyc + 1 + int'(m_len);
                end
                3'd5: if (PEN) m_len = d[15:0];
                default: ;
            endcase
        end
        cyc++;
    endtask

    task automatic step(input bit w, input bit r, input logic [2:0] a,
                        input logic [31:0] d);
        we = w;
        re = r;
        addr = a;
        wdata = d;
        @(posedge clk);
        model_edge(w, r, a, d);
        #1;
        check("ready", 32'(ready), 32'(e_ready));
        check("busy", 32'(busy), 32'(m_busy()));
        check("gpio", 32'(gpio), 32'(m_data ^ (m_busy() ? m_mask : '0)));
        if (w || r) check("rdata", rdata, e_rdata);
        @(negedge clk);
    endtask

    task automatic async_reset();
        we = 1'b0;
        re = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst gpio", 32'(gpio), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst ready", 32'(ready), 32'h0);
        check("rst rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic void add(input bit w, input bit r, input logic [2:0] a,
                                input logic [31:0] d, input logic [W-1:0] g,
                                input logic [31:0] rd);
        vec_t v;
        v.w = w;
        v.r = r;
        v.a = a;
        v.d = d;
        v.g = g;
        v.rd = rd;
        tbl.push_back(v);
    endfunction

    initial begin
        model_reset();
        #2;
        check("init gpio", 32'(gpio), 32'h0);
        check("init busy", 32'(busy), 32'h0);
        check("init ready", 32'(ready), 32'h0);
        check("init rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        add(1, 0, 3'd0, 32'h5A, 8'h5A, 32'h0);
        add(0, 1, 3'd0, 32'h0, 8'h5A, 32'h5A);
        add(0, 1, 3'd1, 32'h0, 8'h5A, 32'h0);
        add(1, 0, 3'd1, 32'h81, 8'hDB, 32'h0);
        add(1, 0, 3'd2, 32'h0A, 8'hD1, 32'h0);
        add(1, 0, 3'd3, 32'hFF, 8'h2E, 32'h0);
        add(0, 1, 3'd3, 32'h0, 8'h2E, 32'h0);
        add(1, 1, 3'd0, 32'h33, 8'h33, 32'h0);
        add(0, 1, 3'd0, 32'h0, 8'h33, 32'h33);
        add(0, 1, 3'd7, 32'h0, 8'h33, 32'h0);
        add(1, 0, 3'd7, 32'hFF, 8'h33, 32'h0);
        add(1, 0, 3'd0, 32'h1FF, 8'hFF, 32'h0);
        add(0, 1, 3'd0, 32'h0, 8'hFF, 32'hFF);
        add(1, 0, 3'd0, 32'h0, 8'h00, 32'h0);
`ifdef GPIO_OUT_PULSE_EN
        add(1, 0, 3'd5, 32'h3, 8'h00, 32'h0);
        add(1, 0, 3'd4, 32'h0F, 8'h0F, 32'h0);
        add(0, 1, 3'd6, 32'h0, 8'h0F, 32'h0003_0001);
        add(0, 1, 3'd6, 32'h0, 8'h0F, 32'h0002_0001);
        add(0, 1, 3'd6, 32'h0, 8'h00, 32'h0001_0001);
        add(0, 1, 3'd6, 32'h0, 8'h00, 32'h0);
        add(1, 0, 3'd5, 32'h5, 8'h00, 32'h0);
        add(1, 0, 3'd4, 32'h01, 8'h01, 32'h0);
        add(1, 0, 3'd4, 32'hF0, 8'h01, 32'h0);
        add(1, 0, 3'd0, 32'h10, 8'h11, 32'h0);
        add(0, 0, 3'd0, 32'h0, 8'h11, 32'h0);
        add(0, 0, 3'd0, 32'h0, 8'h11, 32'h0);
        add(0, 0, 3'd0, 32'h0, 8'h10, 32'h0);
        add(0, 1, 3'd4, 32'h0, 8'h10, 32'h01);
        add(1, 0, 3'd5, 32'h0, 8'h10, 32'h0);
        add(1, 0, 3'd4, 32'hFF, 8'h10, 32'h0);
        add(0, 1, 3'd4, 32'h0, 8'h10, 32'hFF);
        add(0, 1, 3'd5, 32'h0, 8'h10, 32'h0);
`else
        add(1, 0, 3'd5, 32'h5, 8'h00, 32'h0);
        add(1, 0, 3'd4, 32'h0F, 8'h00, 32'h0);
        add(0, 1, 3'd4, 32'h0, 8'h00, 32'h0);
        add(0, 1, 3'd5, 32'h0, 8'h00, 32'h0);
        add(0, 1, 3'd6, 32'h0, 8'h00, 32'h0);
`endif

        foreach (tbl[i]) begin
            step(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
            check($sformatf("vec%0d gpio", i), 32'(gpio), 32'(tbl[i].g));
            if (tbl[i].w || tbl[i].r)
                check($sformatf("vec%0d rdata", i), rdata, tbl[i].rd);
        end

        step(1, 0, 3'd0, 32'h77);
        step(1, 0, 3'd5, 32'd10);
        step(1, 0, 3'd4, 32'hAA);
        step(0, 0, 3'd0, 32'h0);
        async_reset();
        step(1, 1, 3'd0, 32'h33);
        check("wr+rd rdata", rdata, 32'h0);
        check("wr+rd gpio", 32'(gpio), 32'h33);
        step(0, 1, 3'd0, 32'h0);
        check("rd after wr+rd", rdata, 32'h33);

        for (int n = 0; n < 3000; n++) begin
            logic [2:0] a;
            logic [31:0] d;
            bit w;
            bit r;
            a = 3'($urandom_range(0, 7));
            w = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 1) != 0);
            d = (a == 3'd5) ? 32'($urandom_range(0, 6)) : $urandom;
            if ($urandom_range(0, 5) == 0) begin
                w = 1'b0;
                r = 1'b0;
            end
            step(w, r, a, d);
            if (n % 700 == 350) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_out_ctrl.md
Name: gpio_out_ctrl

Overview:
- Memory-mapped GPIO output peripheral for CoreMips; the write-side counterpart of the core's 8-bit GPIO_i input path.
- The core's load/store datapath drives a simple request/ready bus. The block holds the output data register and supports atomic set, clear and toggle writes.
- An optional timed pulse engine inverts selected pins for a programmed number of cycles, then restores them.

Parameters:
- WIDTH, 8, number of GPIO output pins (1..32).
- RESET_VAL, 0, value loaded into the DATA register and driven on GPIO_o at reset.
- LEN_W, 16, width of the pulse length counter in bits (1..16).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous active-high reset.
- addr  in  3  word index of the target register.
- wdata  in  32  write data.
- we  in  1  write request, sampled on the rising edge.
- re  in  1  read request, sampled on the rising edge.
- rdata  out  32  read data, valid only while ready=1.
- ready  out  1  one-cycle acknowledge.
- GPIO_o  out  WIDTH  registered pin outputs.
- busy  out  1  pulse in progress.

Behaviour:
- Reset (asynchronous, active-high): DATA=RESET_VAL, MASK=0, LEN=0, CNT=0, state=IDLE, ready=0, rdata=0, busy=0, GPIO_o=RESET_VAL[WIDTH-1:0].
- Register map (word index):
  - 0 DATA: read/write.
  - 1 SET: write-only; DATA |= wdata. Reads 0.
  - 2 CLR: write-only; DATA &= ~wdata. Reads 0.
  - 3 TOG: write-only; DATA ^= wdata. Reads 0.
  - 4 PULSE: write starts a pulse with MASK=wdata. Read returns MASK.
  - 5 LEN: read/write; only bits [LEN_W-1:0] are stored, other bits read 0.
  - 6 STATUS: read-only; bit0=busy, bits[31:16]=CNT zero-extended, all other bits 0.
  - 7 reserved: reads 0, writes ignored.
- Only bits [WIDTH-1:0] of wdata are used. Unused DATA/MASK bits read 0.
- Handshake:
  - A request is sampled at edge N. ready=1 during cycle N+1 only, then 0. Latency is fixed at 1 cycle; the block never stalls.
  - Back-to-back requests are allowed every cycle; each one gets its own ready pulse.
  - If we and re are both high, the access is treated as a write: rdata=0 with ready.
  - On a write, rdata=0. On a read, rdata holds the register value sampled at edge N.
- GPIO_o is a flop: GPIO_o = DATA ^ (busy ? MASK : 0), updated at every edge. A write at edge N is visible on GPIO_o in cycle N+1, the same cycle as ready.
- Pulse FSM:
  - IDLE, PULSE write with LEN>0: MASK=wdata, CNT=LEN, go to ACTIVE, busy=1 from cycle N+1.
  - IDLE, PULSE write with LEN=0: MASK is stored, no pulse, stay IDLE.
  - ACTIVE: CNT decrements by 1 every cycle. When CNT=1, the next edge sets CNT=0, state=IDLE, busy=0.
  - Pins are therefore inverted for exactly LEN cycles.
  - ACTIVE, PULSE write: ignored (MASK and CNT unchanged), ready still asserted.
  - ACTIVE, LEN write: LEN is updated; the running CNT is unaffected.
  - ACTIVE, DATA/SET/CLR/TOG write: DATA updates immediately; inversion continues on top of the new DATA.
- Reset asserted mid-pulse aborts the pulse at once: GPIO_o=RESET_VAL, busy=0.

Optional Feature:
- Macro: GPIO_OUT_PULSE_EN.
- Defined: pulse FSM, MASK, LEN and CNT are present, with behaviour as above.
- Undefined:
  - Indices 4–6 behave like index 7 (read 0, writes ignored, ready still asserted).
  - busy is tied 0 and GPIO_o = DATA.
  - No MASK, LEN or CNT flops are inferred.

Test Plan:
- Reset, then write DATA=0x5A; read DATA and read SET.
  - Write: ready high for one cycle after the request; GPIO_o=0x5A in the same cycle.
  - DATA read returns 0x5A. SET read returns 0.
- From DATA=0x5A: write SET=0x81, then CLR=0x0A, then TOG=0xFF on consecutive cycles.
  - Expected GPIO_o sequence: 0xDB, 0xD1, 0x2E.
  - Expect 3 consecutive ready pulses.
- DATA=0x00, LEN=3, write PULSE=0x0F.
  - GPIO_o=0x0F and busy=1 for exactly 3 cycles, then GPIO_o=0x00, busy=0.
  - STATUS reads during the pulse show CNT 3, 2, 1.
- During a LEN=5 pulse with MASK=0x01: write PULSE=0xF0 and DATA=0x10.
  - Second PULSE write is ignored.
  - GPIO_o=0x11 while the pulse is active, then 0x10 afterwards.
- LEN=0, write PULSE=0xFF.
  - busy stays 0 and GPIO_o is unchanged.
  - Read of index 4 returns 0xFF.
- Assert rst mid-pulse, asynchronously (not aligned to clk).
  - GPIO_o=RESET_VAL and busy=0 immediately.
  - Simultaneous we+re to DATA=0x33 afterwards: rdata=0, DATA=0x33.
  - Build without GPIO_OUT_PULSE_EN: index 4–6 reads return 0.
